key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
Sequencer between the matrix keyboard scanner and the calculator core. It debounces the scanner's key-present flag and 4-bit key code, turns each physical press into exactly one key event, and queues events in a small FIFO. The core drains the FIFO with a valid/ack handshake. It sits directly downstream of the scanner; the scanner's column rotation (period 4 clocks while no key is seen) is tolerated by the release filter.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive qualifying samples needed to accept a press; legal range ≥2.
RELEASE_CYCLES, 8, consecutive non-matching samples needed to accept a release; legal range ≥8, which exceeds the scan period.
FIFO_DEPTH, 4, event queue entries; must be a power of 2 and ≥2.

Ports:
CLK  in  1  system clock; all logic samples on the rising edge.
RESET_N  in  1  asynchronous, active-low reset.
KEY_READ  in  1  scanner key-present flag.
BCD_KEY  in  4  scanner key code; only meaningful while KEY_READ=1.
KEY_CODE  out  4  code at the FIFO head.
KEY_VALID  out  1  FIFO not empty.
KEY_ACK  in  1  consumer pops the head when KEY_VALID=1.
KEY_COUNT  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
KEY_DOWN  out  1  an accepted key is currently held.
OVERFLOW  out  1  sticky flag: an event was dropped.
CLEAR_OVF  in  1  clears OVERFLOW.

Behaviour:
- Reset (RESET_N=0, takes effect immediately, no clock needed):
  - FSM goes to IDLE; counter=0; candidate code=0.
  - FIFO is emptied.
  - KEY_VALID=0, KEY_CODE=0, KEY_COUNT=0, KEY_DOWN=0, OVERFLOW=0.
  - Entries queued before reset are lost.
  - A key still held when reset is released is debounced again and reported once.
- Qualifying sample: KEY_READ=1 and BCD_KEY equals the candidate code.
- FSM transitions:
  - IDLE: on KEY_READ=1, capture BCD_KEY as candidate, counter=1, go to PRESS_DB.
  - PRESS_DB:
    - On a non-qualifying sample, go to IDLE with counter=0. A different code does not start a new run on that same sample.
    - Otherwise counter+1.
    - On the edge that takes the DEBOUNCE_CYCLES-th consecutive qualifying sample: push the candidate, go to HELD.
  - HELD: on a non-qualifying sample, counter=1 and go to RELEASE_DB. Otherwise stay.
  - RELEASE_DB:
    - On a qualifying sample, go back to HELD (glitch or scan gap). No push.
    - Otherwise counter+1. On the RELEASE_CYCLES-th consecutive non-qualifying sample, go to IDLE.
- KEY_DOWN=1 in HELD and RELEASE_DB; 0 in IDLE and PRESS_DB. It is registered.
- Latency: a pushed entry into an empty FIFO appears on KEY_VALID/KEY_CODE in the cycle after the push edge.
- FIFO behaviour:
  - Show-ahead: KEY_CODE always shows the head entry, and holds its last value when empty.
  - Pop happens on an edge where KEY_VALID=1 and KEY_ACK=1.
  - KEY_ACK while empty is ignored.
  - Order is strictly first-in, first-out. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous events:
  - Push and pop on the same edge: both take effect and KEY_COUNT is unchanged. This also applies when full: the pop frees space, so the push is accepted.
  - Push while full with no pop: the event is dropped, FIFO contents are unchanged, and OVERFLOW=1 from the next cycle.
  - CLEAR_OVF=1 clears OVERFLOW on the next edge. If a drop happens on the same edge, setting wins.
- The counter saturates at its terminal value, so it cannot wrap within a state.
- BCD_KEY is ignored while KEY_READ=0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, RELEASE_CYCLES=8, FIFO_DEPTH=4.
1. Clean press: KEY_READ=1, BCD_KEY=4'hB for 20 cycles, then 0 -> exactly one push; KEY_VALID=1 with KEY_CODE=B starting the cycle after the 4th sample; KEY_DOWN=1 from that same cycle; KEY_DOWN=0 after the 8th low sample.
2. Press bounce: code 4'h3 with KEY_READ 1,1,1,0,1,1,1,1 -> no push from the first run; one push of 3 on the 4th sample of the second run.
3. Release glitch and scan gaps: in HELD with 4'h5, KEY_READ pattern 0,0,0,1 repeated 3 times, then 1 steady -> no second push; KEY_DOWN stays 1 throughout.
4. Code change: during PRESS_DB, 4'h3 for 2 samples, then 4'h7 for 6 samples -> returns to IDLE on the first 7 sample, re-arms on the next; only 7 is pushed, on its 5th sample overall.
5. Overflow: 5 distinct presses (1,2,3,4,5) with KEY_ACK=0 -> KEY_COUNT=4, OVERFLOW=1, KEY_CODE=1. Then KEY_ACK=1 for 4 cycles -> codes 1,2,3,4 in order, KEY_COUNT=0. Then CLEAR_OVF pulse -> OVERFLOW=0.
6. Reset mid-operation: RESET_N=0 in HELD with 2 entries queued -> all outputs 0 immediately without a clock edge. Key 4'h9 still held after RESET_N=1 -> one push of 9 after 4 samples.

Source files
------------

// File: rtl/key_event_if.sv
// Key event bus between the scanner/consumer side and key_event_ctrl.
// The slave modport is the controller; the master modport drives the scanner and consumer signals.
interface key_event_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             KEY_READ;
    logic [3:0]       BCD_KEY;
    logic [3:0]       KEY_CODE;
    logic             KEY_VALID;
    logic             KEY_ACK;
    logic [CNT_W-1:0] KEY_COUNT;
    logic             KEY_DOWN;
    logic             OVERFLOW;
    logic             CLEAR_OVF;

    modport slave (
        input  KEY_READ, BCD_KEY, KEY_ACK, CLEAR_OVF,
        output KEY_CODE, KEY_VALID, KEY_COUNT, KEY_DOWN, OVERFLOW
    );

    modport master (
        output KEY_READ, BCD_KEY, KEY_ACK, CLEAR_OVF,
        input  KEY_CODE, KEY_VALID, KEY_COUNT, KEY_DOWN, OVERFLOW
    );
endinterface

// File: rtl/key_event_ctrl.sv
// Debounces scanner key samples into one event per physical press and queues
// the events in a show-ahead FIFO drained by a valid/ack handshake.
module key_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RELEASE_CYCLES  = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    key_event_if.slave  bus
);
    localparam int MAXC = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int KW   = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_RELEASE_DB} state_t;

    state_t          r_state, w_nstate;
    logic [CW-1:0]   r_cnt, w_ncnt, w_cnt_inc;
    logic [3:0]      r_cand, w_ncand;
    logic            r_down;
    logic            w_qual, w_push;

    logic [3:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [KW-1:0]   r_count;
    logic [3:0]      r_code;
    logic            r_ovf;
    logic            w_pop, w_full, w_push_ok, w_drop;

    assign w_qual    = bus.KEY_READ && (bus.BCD_KEY == r_cand);
    assign w_cnt_inc = (r_cnt == CW'(MAXC)) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            r_down  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_cand  <= w_ncand;
            r_down  <= (w_nstate == S_HELD) || (w_nstate == S_RELEASE_DB);
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_ncand  = r_cand;
        w_push   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.KEY_READ) begin
                    w_ncand  = bus.BCD_KEY;
                    w_ncnt   = CW'(1);
                    w_nstate = S_PRESS_DB;
                end
            end
            S_PRESS_DB: begin
                // A mismatching code only aborts the run; it is re-captured from IDLE next sample.
                if (!w_qual) begin
                    w_ncnt   = '0;
                    w_nstate = S_IDLE;
                end else begin
                    w_ncnt = w_cnt_inc;
                    if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        w_push   = 1'b1;
                        w_nstate = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!w_qual) begin
                    w_ncnt   = CW'(1);
                    w_nstate = S_RELEASE_DB;
                end
            end
            S_RELEASE_DB: begin
                if (w_qual) begin
                    w_nstate = S_HELD;
                end else begin
                    w_ncnt = w_cnt_inc;
                    if (r_cnt == CW'(RELEASE_CYCLES - 1)) begin
                        w_ncnt   = '0;
                        w_nstate = S_IDLE;
                    end
                end
            end
            default: begin
                w_ncnt   = '0;
                w_nstate = S_IDLE;
            end
        endcase
    end

    assign w_pop     = (r_count != '0) && bus.KEY_ACK;
    assign w_full    = (r_count == KW'(FIFO_DEPTH));
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (w_push_ok) r_mem[r_wr] <= r_cand;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_code  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            if (w_pop)     r_rd <= r_rd + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + KW'(1);
                2'b01:   r_count <= r_count - KW'(1);
                default: r_count <= r_count;
            endcase
            // Head register looks ahead to the entry that becomes the head after this edge.
            if (w_pop) begin
                if (r_count > KW'(1))  r_code <= r_mem[r_rd + AW'(1)];
                else if (w_push_ok)    r_code <= r_cand;
            end else if ((r_count == '0) && w_push_ok) begin
                r_code <= r_cand;
            end
            if (w_drop)             r_ovf <= 1'b1;
            else if (bus.CLEAR_OVF) r_ovf <= 1'b0;
        end
    end

    assign bus.KEY_CODE  = r_code;
    assign bus.KEY_VALID = (r_count != '0);
    assign bus.KEY_COUNT = r_count;
    assign bus.KEY_DOWN  = r_down;
    assign bus.OVERFLOW  = r_ovf;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed and randomized bench for key_event_ctrl against a press/release
// run-length model with a queue-based event FIFO.
module tb_key_event_ctrl;
    localparam int DEB   = 4;
    localparam int REL   = 8;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    key_event_if #(.FIFO_DEPTH(DEPTH)) bus ();

    key_event_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .RELEASE_CYCLES (REL),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: press run length, release miss length, event queue.
    bit         m_down;
    logic [3:0] m_cand;
    int         m_run;
    int         m_miss;
    logic [3:0] m_q[$];
    bit         m_ovf;
    logic [3:0] m_code;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_down = 1'b0; m_cand = '0; m_run = 0; m_miss = 0;
        m_q.delete(); m_ovf = 1'b0; m_code = '0;
    endtask

    task automatic model_step(input bit kr, input logic [3:0] bk, input bit ack, input bit clr);
        bit push, pop, drop, match;
        push  = 1'b0;
        drop  = 1'b0;
        pop   = (m_q.size() > 0) && ack;
        match = kr && (bk == m_cand);
        if (!m_down) begin
            if (m_run == 0) begin
                if (kr) begin m_cand = bk; m_run = 1; end
            end else if (match) begin
                m_run++;
                if (m_run == DEB) begin push = 1'b1; m_down = 1'b1; m_miss = 0; end
            end else begin
                m_run = 0;
            end
        end else begin
            if (match) m_miss = 0;
            else begin
                m_miss++;
                if (m_miss == REL) begin m_down = 1'b0; m_run = 0; m_miss = 0; end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_cand);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (m_q.size() > 0) m_code = m_q[0];
    endtask

    task automatic check_outs();
        chk("valid", 32'(bus.KEY_VALID), int'(m_q.size() > 0));
        chk("code",  32'(bus.KEY_CODE),  int'(m_code));
        chk("count", 32'(bus.KEY_COUNT), m_q.size());
        chk("down",  32'(bus.KEY_DOWN),  int'(m_down));
        chk("ovf",   32'(bus.OVERFLOW),  int'(m_ovf));
    endtask

    // Called at a falling edge: drive, let the rising edge sample, check at the next falling edge.
    task automatic step(input bit kr, input logic [3:0] bk, input bit ack, input bit clr);
        bus.KEY_READ  = kr;
        bus.BCD_KEY   = bk;
        bus.KEY_ACK   = ack;
        bus.CLEAR_OVF = clr;
        @(posedge CLK);
        model_step(kr, bk, ack, clr);
        @(negedge CLK);
        check_outs();
    endtask

    task automatic release_keys(input bit ack_first);
        for (int i = 0; i < REL; i++) step(1'b0, 4'h0, ack_first && (i == 0), 1'b0);
    endtask

    initial begin
        logic [3:0] code;
        bit kr;
        int r;
        bus.KEY_READ = 1'b0; bus.BCD_KEY = '0; bus.KEY_ACK = 1'b0; bus.CLEAR_OVF = 1'b0;
        model_reset();
        #1;
        check_outs();
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        // Clean press of B
        for (int i = 0; i < DEB; i++) begin
            step(1'b1, 4'hB, 1'b0, 1'b0);
            if (i == DEB - 2) chk("s1_early_valid", 32'(bus.KEY_VALID), 0);
        end
        chk("s1_valid", 32'(bus.KEY_VALID), 1);
        chk("s1_code",  32'(bus.KEY_CODE), 'hB);
        chk("s1_down",  32'(bus.KEY_DOWN), 1);
        repeat (16) step(1'b1, 4'hB, 1'b0, 1'b0);
        for (int i = 0; i < REL; i++) begin
            step(1'b0, 4'h0, 1'b0, 1'b0);
            if (i == REL - 2) chk("s1_down_held", 32'(bus.KEY_DOWN), 1);
        end
        chk("s1_down_rel", 32'(bus.KEY_DOWN), 0);
        chk("s1_count", 32'(bus.KEY_COUNT), 1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("s1_drained", 32'(bus.KEY_COUNT), 0);

        // Press bounce on 3
        repeat (3) step(1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b0, 4'h3, 1'b0, 1'b0);
        repeat (3) step(1'b1, 4'h3, 1'b0, 1'b0);
        chk("s2_no_early", 32'(bus.KEY_VALID), 0);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        chk("s2_push", 32'(bus.KEY_CODE), 3);
        release_keys(1'b1);

        // Release glitches and scan gaps on 5
        repeat (DEB) step(1'b1, 4'h5, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                step(j == 3, 4'h5, 1'b0, 1'b0);
                chk("s3_down", 32'(bus.KEY_DOWN), 1);
            end
        end
        repeat (5) step(1'b1, 4'h5, 1'b0, 1'b0);
        chk("s3_one_push", 32'(bus.KEY_COUNT), 1);
        release_keys(1'b1);

        // Code change during press debounce
        repeat (2) step(1'b1, 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'h7, 1'b0, 1'b0);
            if (i == 3) chk("s4_not_yet", 32'(bus.KEY_VALID), 0);
        end
        chk("s4_code", 32'(bus.KEY_CODE), 7);
        chk("s4_count", 32'(bus.KEY_COUNT), 1);
        release_keys(1'b1);

        // Overflow with five presses and no ack
        for (int k = 1; k <= 5; k++) begin
            repeat (DEB) step(1'b1, 4'(k), 1'b0, 1'b0);
            release_keys(1'b0);
        end
        chk("s5_count", 32'(bus.KEY_COUNT), 4);
        chk("s5_ovf",   32'(bus.OVERFLOW), 1);
        chk("s5_head",  32'(bus.KEY_CODE), 1);
        for (int i = 0; i < 4; i++) begin
            chk("s5_order", 32'(bus.KEY_CODE), i + 1);
            step(1'b0, 4'h0, 1'b1, 1'b0);
        end
        chk("s5_empty", 32'(bus.KEY_COUNT), 0);
        chk("s5_ovf_sticky", 32'(bus.OVERFLOW), 1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("s5_ovf_clr", 32'(bus.OVERFLOW), 0);

        // Asynchronous reset while held with two queued entries
        repeat (DEB) step(1'b1, 4'h9, 1'b0, 1'b0);
        release_keys(1'b0);
        repeat (DEB) step(1'b1, 4'h9, 1'b0, 1'b0);
        chk("s6_pre_count", 32'(bus.KEY_COUNT), 2);
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        chk("s6_rst_valid", 32'(bus.KEY_VALID), 0);
        chk("s6_rst_code",  32'(bus.KEY_CODE), 0);
        chk("s6_rst_count", 32'(bus.KEY_COUNT), 0);
        chk("s6_rst_down",  32'(bus.KEY_DOWN), 0);
        chk("s6_rst_ovf",   32'(bus.OVERFLOW), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < DEB; i++) begin
            step(1'b1, 4'h9, 1'b0, 1'b0);
            if (i == DEB - 2) chk("s6_rearm_wait", 32'(bus.KEY_VALID), 0);
        end
        chk("s6_push", 32'(bus.KEY_CODE), 9);
        chk("s6_count", 32'(bus.KEY_COUNT), 1);
        release_keys(1'b1);

        // Randomized presses with bounce, scan gaps, random ack and clear
        for (int seg = 0; seg < 300; seg++) begin
            code = 4'($urandom_range(0, 15));
            for (int i = 0, n = $urandom_range(1, 14); i < n; i++) begin
                kr = ($urandom_range(0, 9) != 0);
                step(kr, code, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
            end
            for (int i = 0, n = $urandom_range(1, 14); i < n; i++) begin
                r  = $urandom_range(0, 9);
                kr = (r < 2);
                step(kr, (r == 0) ? code : 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
